// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
//   Receive-side checker for a VGA pixel stream. Samples hsync/vsync and the
//   12-bit colour at pixel rate and verifies the line/frame timing. It tracks
//   whether the source is locked and reports a 16-bit sum of the active pixels
//   of every good frame.
//
// Ports
//   i_clock        system clock (only clock)
//   i_reset        synchronous, active-high reset
//   i_pix_en       pixel-rate enable; all sampling and state updates happen only when high
//   i_hsync        horizontal sync, active low
//   i_vsync        vertical sync, active low
//   i_vga_r/g/b    colour nibbles, pixel = {r,g,b}
//   o_locked       timing locked
//   o_frame_done   one-clock pulse when a frame was checked good while locked
//   o_frame_crc    active-pixel sum of the last good frame (mod 2^16)
//   o_frame_count  good frames since reset (wraps)
//   o_err_count    timing errors seen while aligning or locked (saturates at 255)
module vga_frame_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_TOTAL  = 525
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pix_en,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [3:0]  i_vga_r,
  input  logic [3:0]  i_vga_g,
  input  logic [3:0]  i_vga_b,
  output logic        o_locked,
  output logic        o_frame_done,
  output logic [15:0] o_frame_crc,
  output logic [15:0] o_frame_count,
  output logic [7:0]  o_err_count
);

  localparam logic [10:0] L_H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] L_H_SYNC_LAST = 11'(H_SYNC - 1);
  localparam logic [10:0] L_H_WDOG_PRE  = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] L_H_ACT_LO    = 11'(H_SYNC + H_BP);
  localparam logic [10:0] L_H_ACT_HI    = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  L_V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  L_V_SYNC      = 10'(V_SYNC);
  localparam logic [9:0]  L_V_ACT_LO    = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  L_V_ACT_HI    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_ALIGN  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_hs_d;
  logic        r_vs_d;
  logic [10:0] r_h_pos;
  logic [9:0]  r_lc;
  logic [15:0] r_acc;
  logic        r_clean;
  logic        r_locked;
  logic        r_frame_done;
  logic [15:0] r_frame_crc;
  logic [15:0] r_frame_count;
  logic [7:0]  r_err_count;

  logic [11:0] w_pixel;
  logic        w_hfall;
  logic        w_hrise;
  logic        w_vfall;
  logic        w_vrise;
  logic [10:0] w_h_pos_next;
  logic [9:0]  w_lc_next;
  logic        w_active;
  logic [15:0] w_acc_next;
  logic        w_timing_bad;
  logic        w_clean_next;
  logic        w_err_inc;
  logic        w_done_next;

  assign w_pixel = {i_vga_r, i_vga_g, i_vga_b};
  assign w_hfall = r_hs_d & ~i_hsync;
  assign w_hrise = ~r_hs_d & i_hsync;
  assign w_vfall = r_vs_d & ~i_vsync;
  assign w_vrise = ~r_vs_d & i_vsync;

  // Position counters saturate so a dead source cannot wrap back into range.
  assign w_h_pos_next = w_hfall ? 11'd0 :
                        (r_h_pos == 11'h7FF) ? r_h_pos : r_h_pos + 11'd1;
  assign w_lc_next    = w_vfall ? 10'd0 :
                        (w_hfall && r_lc != 10'h3FF) ? r_lc + 10'd1 : r_lc;

  // Edge checks use the counter value held before this tick. vrise lands on
  // the hfall that opens the first non-sync line, so it is judged against the
  // line number being entered.
  assign w_timing_bad = (w_hfall && r_h_pos != L_H_LAST) ||
                        (w_hrise && r_h_pos != L_H_SYNC_LAST) ||
                        (w_vfall && r_lc != L_V_LAST) ||
                        (w_vrise && w_lc_next != L_V_SYNC) ||
                        (!w_hfall && r_h_pos == L_H_WDOG_PRE);

  assign w_active = (r_h_pos >= L_H_ACT_LO) && (r_h_pos <= L_H_ACT_HI) &&
                    (r_lc >= L_V_ACT_LO) && (r_lc <= L_V_ACT_HI);

  assign w_acc_next = w_vfall ? 16'd0 :
                      w_active ? r_acc + {4'b0000, w_pixel} : r_acc;

  // r_clean marks that the frame in progress started at a vfall and has had
  // no timing error yet; ALIGN needs one such frame before locking.
  always_comb begin
    w_state_next = r_state;
    w_clean_next = r_clean;
    w_err_inc    = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      S_SEARCH: begin
        if (w_vfall) begin
          w_state_next = S_ALIGN;
          w_clean_next = 1'b1;
        end
      end
      S_ALIGN: begin
        if (w_timing_bad) begin
          w_err_inc    = 1'b1;
          w_clean_next = 1'b0;
        end else if (w_vfall) begin
          if (r_clean) begin
            w_state_next = S_LOCKED;
          end else begin
            w_clean_next = 1'b1;
          end
        end
      end
      S_LOCKED: begin
        // An error on the closing vfall discards the frame.
        if (w_timing_bad) begin
          w_err_inc    = 1'b1;
          w_state_next = S_SEARCH;
        end else if (w_vfall) begin
          w_done_next = 1'b1;
        end
      end
      default: begin
        w_state_next = S_SEARCH;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_SEARCH;
    end else if (i_pix_en) begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hs_d        <= 1'b1;
      r_vs_d        <= 1'b1;
      r_h_pos       <= 11'd0;
      r_lc          <= 10'd0;
      r_acc         <= 16'd0;
      r_clean       <= 1'b0;
      r_locked      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_crc   <= 16'd0;
      r_frame_count <= 16'd0;
      r_err_count   <= 8'd0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_pix_en) begin
        r_hs_d       <= i_hsync;
        r_vs_d       <= i_vsync;
        r_h_pos      <= w_h_pos_next;
        r_lc         <= w_lc_next;
        r_acc        <= w_acc_next;
        r_clean      <= w_clean_next;
        r_locked     <= (w_state_next == S_LOCKED);
        r_frame_done <= w_done_next;
        if (w_done_next) begin
          r_frame_crc   <= r_acc;
          r_frame_count <= r_frame_count + 16'd1;
        end
        if (w_err_inc && r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  assign o_locked      = r_locked;
  assign o_frame_done  = r_frame_done;
  assign o_frame_crc   = r_frame_crc;
  assign o_frame_count = r_frame_count;
  assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor
//   Drives a scaled-down VGA source (16 ticks/line, 12 lines/frame) into the
//   monitor with a 1-in-4 pixel enable. Expected frame_done results are queued
//   when the closing vfall is driven and popped by a separate monitor process.
module tb_vga_frame_monitor;

  localparam int H_ACTIVE = 8;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int H_TOTAL  = 16;
  localparam int V_ACTIVE = 6;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_TOTAL  = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_crc;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  vga_frame_monitor #(
    .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL)
  ) dut (
    .i_clock      (clk),
    .i_reset      (reset),
    .i_pix_en     (pix_en),
    .i_hsync      (hsync),
    .i_vsync      (vsync),
    .i_vga_r      (vga_r),
    .i_vga_g      (vga_g),
    .i_vga_b      (vga_b),
    .o_locked     (locked),
    .o_frame_done (frame_done),
    .o_frame_crc  (frame_crc),
    .o_frame_count(frame_count),
    .o_err_count  (err_count)
  );

  typedef struct packed {
    logic [15:0] crc;
    logic [15:0] count;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] frame_sum;
  logic [15:0] last_sum;
  logic [15:0] last_crc;
  logic [15:0] exp_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One pixel-enable tick: inputs set, enable high for one clock, then three idle clocks.
  task automatic tick(input logic hs, input logic vs, input logic [11:0] px);
    hsync  = hs;
    vsync  = vs;
    {vga_r, vga_g, vga_b} = px;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic line(input int len, input int hsw, input logic vs, input logic [11:0] px, input int t0);
    for (int t = t0; t < len; t++) begin
      tick((t < hsw) ? 1'b0 : 1'b1, vs, px);
    end
  endtask

  // Expected sum: each active line contributes H_ACTIVE copies of its pixel.
  task automatic add_line(input int l, input logic [11:0] px);
    if (l >= V_SYNC + V_BP && l < V_SYNC + V_BP + V_ACTIVE) begin
      frame_sum = frame_sum + 16'(H_ACTIVE * int'(px));
    end
  endtask

  task automatic lines(input int from, input int to, input logic [11:0] base);
    for (int l = from; l <= to; l++) begin
      line(H_TOTAL, H_SYNC, (l < V_SYNC) ? 1'b0 : 1'b1, base + 12'(l), 0);
      add_line(l, base + 12'(l));
    end
  endtask

  // Called just before the vfall of a new frame; queues the result that vfall should report.
  task automatic start_frame(input bit exp_done);
    if (exp_done) begin
      exp_count = exp_count + 16'd1;
      exp_q.push_back('{crc: last_sum, count: exp_count});
      last_crc = last_sum;
    end
    frame_sum = 16'd0;
  endtask

  task automatic end_frame();
    last_sum = frame_sum;
    chk("done_pending", exp_q.size(), 0);
  endtask

  task automatic frame(input bit exp_done, input logic [11:0] base);
    start_frame(exp_done);
    lines(0, V_TOTAL - 1, base);
    end_frame();
  endtask

  // Scoreboard monitor: every frame_done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL frame_done_unexpected: got pulse crc=%h count=%0d, required no pulse",
                   frame_crc, frame_count);
        end else begin
          e = exp_q.pop_front();
          $display("frame_done: crc=%h count=%0d (expected crc=%h count=%0d)",
                   frame_crc, frame_count, e.crc, e.count);
          chk("frame_crc", frame_crc, e.crc);
          chk("frame_count", frame_count, e.count);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    pix_en = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    {vga_r, vga_g, vga_b} = 12'h000;
    exp_count = 16'd0;
    last_sum = 16'd0;
    last_crc = 16'd0;
    frame_sum = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_locked", locked, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_crc", frame_crc, 0);
    chk("reset_count", frame_count, 0);
    chk("reset_err", err_count, 0);
    reset = 1'b0;

    // Ideal source: lock at 2nd vfall, first result at 3rd (8*(5+..+10) = 0x0168).
    frame(0, 12'h7A0);
    chk("t1_locked_f1", locked, 0);
    frame(0, 12'h001);
    chk("t1_locked_f2", locked, 1);
    frame(1, 12'hFFC);
    frame(1, 12'h3C5);
    chk("t1_err", err_count, 0);
    chk("t1_count", frame_count, 2);
    chk("t1_locked", locked, 1);

    // One line one tick short: error on the following hfall, lock dropped at once.
    start_frame(1);
    lines(0, 4, 12'h111);
    line(H_TOTAL - 1, H_SYNC, 1'b1, 12'h116, 0);
    chk("t2_locked_before", locked, 1);
    chk("t2_err_before", err_count, 0);
    tick(1'b0, 1'b1, 12'h117);
    chk("t2_locked_after", locked, 0);
    chk("t2_err_after", err_count, 1);
    line(H_TOTAL, H_SYNC, 1'b1, 12'h117, 1);
    lines(7, 11, 12'h111);
    end_frame();
    frame(0, 12'h222);
    chk("t2_locked_f6", locked, 0);
    frame(0, 12'h333);
    chk("t2_relock", locked, 1);
    chk("t2_count", frame_count, 3);

    // Short hsync pulse; a later bad line in SEARCH must not count.
    start_frame(1);
    lines(0, 3, 12'h444);
    line(H_TOTAL, H_SYNC - 1, 1'b1, 12'h448, 0);
    chk("t3_locked", locked, 0);
    chk("t3_err", err_count, 2);
    lines(5, 5, 12'h444);
    line(H_TOTAL - 1, H_SYNC, 1'b1, 12'h44A, 0);
    lines(7, 11, 12'h444);
    end_frame();
    chk("t3_err_search", err_count, 2);
    frame(0, 12'h555);
    frame(0, 12'h666);
    chk("t3_relock", locked, 1);
    chk("t3_count", frame_count, 4);

    // hsync stuck high: watchdog fires as h_pos reaches 2*H_TOTAL.
    start_frame(1);
    lines(0, 5, 12'h777);
    repeat (H_TOTAL) tick(1'b1, 1'b1, 12'h77D);
    chk("t4_locked_before", locked, 1);
    chk("t4_err_before", err_count, 2);
    tick(1'b1, 1'b1, 12'h77D);
    chk("t4_locked_after", locked, 0);
    chk("t4_err_after", err_count, 3);
    repeat (40) tick(1'b1, 1'b1, 12'h77D);
    chk("t4_err_hold", err_count, 3);
    lines(6, 11, 12'h777);
    end_frame();
    frame(0, 12'h888);
    frame(0, 12'h999);
    chk("t4_relock", locked, 1);
    chk("t4_count", frame_count, 5);

    // pix_en low for 1000 clocks mid-line while the pins carry garbage.
    start_frame(1);
    lines(0, 5, 12'hAAA);
    line(8, H_SYNC, 1'b1, 12'hAB0, 0);
    hsync = 1'b0;
    vsync = 1'b0;
    {vga_r, vga_g, vga_b} = 12'hFFF;
    repeat (1000) begin
      @(posedge clk);
      #1;
      hsync = ~hsync;
    end
    chk("t5_locked", locked, 1);
    chk("t5_err", err_count, 3);
    chk("t5_count", frame_count, 6);
    chk("t5_crc", frame_crc, last_crc);
    chk("t5_done", frame_done, 0);
    line(H_TOTAL, H_SYNC, 1'b1, 12'hAB0, 8);
    add_line(6, 12'hAB0);
    lines(7, 11, 12'hAAA);
    end_frame();
    frame(1, 12'hBBB);
    chk("t5_locked_after", locked, 1);
    chk("t5_err_after", err_count, 3);
    chk("t5_count_after", frame_count, 7);

    // Error on the closing vfall while locked: error wins, no frame_done.
    start_frame(1);
    lines(0, 10, 12'hCCC);
    line(H_TOTAL - 1, H_SYNC, 1'b1, 12'hCD7, 0);
    end_frame();
    start_frame(0);
    lines(0, 0, 12'hDDD);
    chk("sim_locked", locked, 0);
    chk("sim_err", err_count, 4);
    chk("sim_count", frame_count, 8);
    lines(1, 11, 12'hDDD);
    end_frame();
    frame(0, 12'hEEE);
    frame(0, 12'h0F0);
    chk("sim_relock", locked, 1);

    // Reset mid-frame while locked, then saturate err_count in ALIGN.
    start_frame(1);
    lines(0, 5, 12'h123);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_locked", locked, 0);
    chk("t6_done", frame_done, 0);
    chk("t6_crc", frame_crc, 0);
    chk("t6_count", frame_count, 0);
    chk("t6_err", err_count, 0);
    reset = 1'b0;
    exp_count = 16'd0;
    chk("t6_pending", exp_q.size(), 0);
    line(H_TOTAL, H_SYNC, 1'b0, 12'h000, 0);
    line(H_TOTAL, H_SYNC, 1'b0, 12'h000, 0);
    repeat (200) line(H_TOTAL - 1, H_SYNC, 1'b1, 12'h000, 0);
    chk("t6_err_mid", err_count, 199);
    chk("t6_locked_mid", locked, 0);
    repeat (100) line(H_TOTAL - 1, H_SYNC, 1'b1, 12'h000, 0);
    line(H_TOTAL, H_SYNC, 1'b1, 12'h000, 0);
    chk("t6_err_sat", err_count, 255);
    chk("t6_locked_end", locked, 0);
    chk("t6_count_end", frame_count, 0);
    chk("final_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
